// File: rtl/dt_pkg.sv
// Shared constants and types for the result-image packer.
package dt_pkg;

    localparam int IMG_W    = 128;   // image edge length in pixels
    localparam int PIX_AW   = 14;    // pixel address width (128*128 pixels)
    localparam int STI_AW   = 10;    // packed-word address width
    localparam int STI_DW   = 16;    // packed-word width, one bit per pixel
    localparam int PIX_BITS = 4;     // pixel-in-word index width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        FIN  = 2'd3
    } state_t;

    // Pixel address of pixel 'pix' inside packed word 'word'.
    function automatic logic [PIX_AW-1:0] pix_addr(input logic [STI_AW-1:0]   word,
                                                   input logic [PIX_BITS-1:0] pix);
        return {word, pix};
    endfunction

endpackage

// File: rtl/res_pack_if.sv
// Memory-side and control signals of the packer, grouped into one bundle.
interface res_pack_if;
    import dt_pkg::*;

    logic                start;
    logic                res_rd;
    logic [PIX_AW-1:0]   res_addr;
    logic [7:0]          res_di;
    logic                sti_wr;
    logic [STI_AW-1:0]   sti_addr;
    logic [STI_DW-1:0]   sti_do;
    logic                busy;
    logic                done;

    // Packer side.
    modport master (
        input  start,
        input  res_di,
        output res_rd,
        output res_addr,
        output sti_wr,
        output sti_addr,
        output sti_do,
        output busy,
        output done
    );

    // Environment side: memories and the run controller.
    modport slave (
        output start,
        output res_di,
        input  res_rd,
        input  res_addr,
        input  sti_wr,
        input  sti_addr,
        input  sti_do,
        input  busy,
        input  done
    );

endinterface

// File: rtl/bit_packer.sv
// Shift register that collects one thresholded bit per pixel, MSB first.
module bit_packer #(
    parameter int         W      = 16,
    parameter logic [7:0] THRESH = 8'h00
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [7:0]   i_byte,
    output logic [W-1:0] o_data
);

    logic [W-1:0] r_shift;
    logic [W-1:0] w_shifted;
    logic         w_bit;

    assign w_bit = (i_byte > THRESH);

    // Newest pixel enters at bit 0, so the first pixel ends up in the MSB.
    assign w_shifted[0] = w_bit;
    generate
        for (genvar gi = 1; gi < W; gi++) begin : g_shift
            assign w_shifted[gi] = r_shift[gi-1];
        end
    endgenerate

    // Shift register: clear wins over shift.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift <= '0;
        end else if (i_clr) begin
            r_shift <= '0;
        end else if (i_en) begin
            r_shift <= w_shifted;
        end
    end

    assign o_data = r_shift;

endmodule

// File: rtl/res_pack.sv
// Reads 16 result bytes per word, thresholds them and writes one packed word.
module res_pack
    import dt_pkg::*;
#(
    parameter int         WORDS  = 1024,
    parameter logic [7:0] THRESH = 8'h00
) (
    input  logic      clk,
    input  logic      reset,
    res_pack_if.master bus
);

    localparam logic [STI_AW-1:0]   LAST_WORD = STI_AW'(WORDS - 1);
    localparam logic [PIX_BITS-1:0] LAST_PIX  = '1;

    state_t              r_state,    w_state_next;
    logic [STI_AW-1:0]   r_word,     w_word_next;
    logic [PIX_BITS-1:0] r_pix,      w_pix_next;
    logic                r_res_rd,   w_res_rd_next;
    logic [PIX_AW-1:0]   r_res_addr, w_res_addr_next;
    logic                r_sti_wr,   w_sti_wr_next;
    logic [STI_AW-1:0]   r_sti_addr, w_sti_addr_next;
    logic                r_busy,     w_busy_next;
    logic                r_done,     w_done_next;

    logic                w_shift_en;
    logic                w_clr;
    logic [STI_DW-1:0]   w_packed;

    // The byte for the current RD cycle arrives before the cycle-ending edge.
    assign w_shift_en = (r_state == RD);
    assign w_clr      = (r_state == IDLE) && bus.start;

    bit_packer #(
        .W      (STI_DW),
        .THRESH (THRESH)
    ) u_bit_packer (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (w_clr),
        .i_en   (w_shift_en),
        .i_byte (bus.res_di),
        .o_data (w_packed)
    );

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_word     <= '0;
            r_pix      <= '0;
            r_res_rd   <= 1'b0;
            r_res_addr <= '0;
            r_sti_wr   <= 1'b0;
            r_sti_addr <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_word     <= w_word_next;
            r_pix      <= w_pix_next;
            r_res_rd   <= w_res_rd_next;
            r_res_addr <= w_res_addr_next;
            r_sti_wr   <= w_sti_wr_next;
            r_sti_addr <= w_sti_addr_next;
            r_busy     <= w_busy_next;
            r_done     <= w_done_next;
        end
    end

    // Next state plus the output values for the cycle that follows.
    always_comb begin
        w_state_next    = r_state;
        w_word_next     = r_word;
        w_pix_next      = r_pix;
        w_res_rd_next   = 1'b0;
        w_res_addr_next = r_res_addr;
        w_sti_wr_next   = 1'b0;
        w_sti_addr_next = r_sti_addr;
        w_busy_next     = 1'b0;
        w_done_next     = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state_next    = RD;
                    w_word_next     = '0;
                    w_pix_next      = '0;
                    w_res_rd_next   = 1'b1;
                    w_res_addr_next = pix_addr('0, '0);
                    w_busy_next     = 1'b1;
                end
            end

            RD: begin
                w_pix_next  = r_pix + 1'b1;
                w_busy_next = 1'b1;
                if (r_pix == LAST_PIX) begin
                    w_state_next    = WR;
                    w_sti_wr_next   = 1'b1;
                    w_sti_addr_next = r_word;
                end else begin
                    w_res_rd_next   = 1'b1;
                    w_res_addr_next = pix_addr(r_word, r_pix + 1'b1);
                end
            end

            WR: begin
                if (r_word == LAST_WORD) begin
                    w_state_next = FIN;
                    w_done_next  = 1'b1;
                end else begin
                    w_state_next    = RD;
                    w_word_next     = r_word + 1'b1;
                    w_pix_next      = '0;
                    w_res_rd_next   = 1'b1;
                    w_res_addr_next = pix_addr(r_word + 1'b1, '0);
                    w_busy_next     = 1'b1;
                end
            end

            FIN: begin
                w_state_next = IDLE;
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign bus.res_rd   = r_res_rd;
    assign bus.res_addr = r_res_addr;
    assign bus.sti_wr   = r_sti_wr;
    assign bus.sti_addr = r_sti_addr;
    assign bus.sti_do   = w_packed;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;

endmodule
